herald_mac_pipe: RTL



---
 rtl/herald_mac_pipe.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/herald_mac_pipe.sv
// ----------------------------------------------------------------------------
// herald_mac_pipe
//
// Multi-channel signed multiply-accumulate engine with a two-stage pipeline
// and valid/ready handshakes on both sides. Stage 1 registers the command
// together with the full-width product. Stage 2 does the read-modify-write
// of the selected channel accumulator and loads the result into the output
// register. Stage 2 is the only accumulator writer, so back-to-back
// commands on one channel see each other's results without bubbles.
//
// Optional feature macro: HERALD_MAC_SAT_EN
//   defined   : MAC results clamp to the accumulator range and set a
//               per-channel sticky saturation flag
//   undefined : MAC results wrap modulo 2**ACC_W; sticky flags and out_sat
//               are tied to 0
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   ena        design enable, gates acceptance of new commands only
//   in_valid   command present
//   in_ready   command accepted when in_valid && in_ready at rising edge
//   in_op      00 MAC, 01 LOAD, 10 CLEAR, 11 READ
//   in_ch      target channel
//   in_a/in_b  signed operands
//   out_valid  result beat present
//   out_ready  consumer accepts beat
//   out_data   channel accumulator value after the op
//   out_ch     channel of this beat
//   out_sat    sticky saturation flag of out_ch after the op
//   busy       some pipeline stage holds a valid op
// ----------------------------------------------------------------------------
module herald_mac_pipe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int NCH    = 4,
    parameter int CH_W   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [CH_W-1:0]          in_ch,
    input  logic signed [DATA_W-1:0] in_a,
    input  logic signed [DATA_W-1:0] in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_sat,
    output logic                     busy
);

    typedef enum logic [1:0] {
        OP_MAC   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_CLEAR = 2'b10,
        OP_READ  = 2'b11
    } opE;

    localparam int PROD_W = 2 * DATA_W;

    // Stage 1 registers
    logic                     r_s1Valid;
    opE                       r_s1Op;
    logic [CH_W-1:0]          r_s1Ch;
    logic signed [PROD_W-1:0] r_s1Prod;

    // Stage 2 / output registers
    logic                     r_outValid;
    logic signed [ACC_W-1:0]  r_outData;
    logic [CH_W-1:0]          r_outCh;
    logic                     r_outSat;

    // Channel accumulators
    logic signed [ACC_W-1:0]  r_acc [NCH];

    logic                     w_stall;
    logic                     w_accept;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prodExt;
    logic                     w_chOk;
    logic signed [ACC_W-1:0]  w_accCur;
    logic                     w_satCur;
    logic signed [ACC_W-1:0]  w_newAcc;
    logic                     w_newSat;

    // The output register is the only place a beat can wait, so a held beat
    // freezes the whole pipeline and closes the input.
    assign w_stall  = r_outValid && !out_ready;
    assign in_ready = ena && !w_stall;
    assign w_accept = in_valid && in_ready;

    assign w_prod    = in_a * in_b;
    assign w_prodExt = ACC_W'(r_s1Prod);

    // Channels beyond NCH produce a zero beat and never touch state.
    assign w_chOk   = (int'(r_s1Ch) < NCH);
    assign w_accCur = w_chOk ? r_acc[r_s1Ch] : '0;

`ifdef HERALD_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic                     r_sat [NCH];
    logic signed [ACC_W:0]    w_sum;

    // One extra bit keeps the true sum; overflow shows as top two bits differing.
    assign w_sum    = (ACC_W+1)'(w_accCur) + (ACC_W+1)'(w_prodExt);
    assign w_satCur = w_chOk ? r_sat[r_s1Ch] : 1'b0;
`else
    assign w_satCur = 1'b0;
`endif

    // Next accumulator value and sticky flag for the op sitting in stage 1.
    always_comb begin
        w_newAcc = w_accCur;
        w_newSat = w_satCur;
        case (r_s1Op)
            OP_MAC: begin
`ifdef HERALD_MAC_SAT_EN
                if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
                    w_newAcc = w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
                    w_newSat = 1'b1;
                end else begin
                    w_newAcc = w_sum[ACC_W-1:0];
                end
`else
                w_newAcc = w_accCur + w_prodExt;
`endif
            end
            OP_LOAD: begin
                w_newAcc = w_prodExt;
            end
            OP_CLEAR: begin
                w_newAcc = '0;
                w_newSat = 1'b0;
            end
            default: begin
                w_newAcc = w_accCur;
            end
        endcase
    end

    // Pipeline advance: stage 1 captures accepted commands, stage 2 writes the
    // accumulator and the output register. Nothing moves while stalled, and
    // reset drops anything in flight without emitting a beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1Valid  <= 1'b0;
            r_s1Op     <= OP_READ;
            r_s1Ch     <= '0;
            r_s1Prod   <= '0;
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outCh    <= '0;
            r_outSat   <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                r_acc[i] <= '0;
`ifdef HERALD_MAC_SAT_EN
                r_sat[i] <= 1'b0;
`endif
            end
        end else if (!w_stall) begin
            r_s1Valid <= w_accept;
            if (w_accept) begin
                r_s1Op   <= opE'(in_op);
                r_s1Ch   <= in_ch;
                r_s1Prod <= w_prod;
            end
            r_outValid <= r_s1Valid;
            if (r_s1Valid) begin
                r_outCh   <= r_s1Ch;
                r_outData <= w_chOk ? w_newAcc : '0;
                r_outSat  <= w_chOk ? w_newSat : 1'b0;
                if (w_chOk) begin
                    r_acc[r_s1Ch] <= w_newAcc;
`ifdef HERALD_MAC_SAT_EN
                    r_sat[r_s1Ch] <= w_newSat;
`endif
                end
            end
        end
    end

    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_ch    = r_outCh;
    assign out_sat   = r_outSat;
    assign busy      = r_s1Valid || r_outValid;

endmodule
